// File: rtl/ram_master.sv
// ram_master: turns read/write burst commands into per-cycle block RAM port activity
// and returns read beats as a last-flagged response stream.
module ram_master #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  busy,
  output logic                  mem_w_en,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  output logic                  mem_r_en,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  input  logic [DATA_WIDTH-1:0] mem_r_data
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] beats_left_q, beats_left_d;
  logic [RD_LAT-1:0]     pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0]     pipe_last_q, pipe_last_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_last_q, rsp_last_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  push_vld;
  logic                  push_last;

  // Burst sequencing and RAM port drive
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    push_vld     = 1'b0;
    push_last    = 1'b0;
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    mem_w_en     = 1'b0;
    mem_w_addr   = '0;
    mem_w_data   = '0;
    mem_r_en     = 1'b0;
    mem_r_addr   = '0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
      end
      WRITE: begin
        wr_ready   = 1'b1;
        mem_w_en   = wr_valid;
        mem_w_addr = cur_addr_q;
        mem_w_data = wr_data;
        if (wr_valid) begin
          cur_addr_d   = cur_addr_q + ADDR_WIDTH'(1);
          beats_left_d = beats_left_q - ADDR_WIDTH'(1);
          if (beats_left_q == '0) begin
            state_d = IDLE;
          end
        end
      end
      READ: begin
        mem_r_en     = 1'b1;
        mem_r_addr   = cur_addr_q;
        push_vld     = 1'b1;
        push_last    = (beats_left_q == '0);
        cur_addr_d   = cur_addr_q + ADDR_WIDTH'(1);
        beats_left_d = beats_left_q - ADDR_WIDTH'(1);
        if (beats_left_q == '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Accepting in the last-beat cycle removes the dead cycle between read bursts
        cmd_ready = rsp_valid_q && rsp_last_q;
        if (rsp_valid_q && rsp_last_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cmd_valid && cmd_ready) begin
      cur_addr_d   = cmd_addr;
      beats_left_d = cmd_len;
      state_d      = cmd_write ? WRITE : READ;
    end
  end

  // In-flight tag pipeline aligned with the RAM read latency
  always_comb begin
    pipe_vld_d     = pipe_vld_q;
    pipe_last_d    = pipe_last_q;
    pipe_vld_d[0]  = push_vld;
    pipe_last_d[0] = push_last;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end
    rsp_valid_d = pipe_vld_q[RD_LAT-1];
    rsp_last_d  = pipe_vld_q[RD_LAT-1] && pipe_last_q[RD_LAT-1];
    rsp_data_d  = pipe_vld_q[RD_LAT-1] ? mem_r_data : rsp_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      pipe_vld_q   <= '0;
      pipe_last_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_last_q   <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_last_q  <= pipe_last_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_last_q   <= rsp_last_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master: cycle vectors for single and wrapping bursts, plus
// hand sequences for a full read with a queued command, reset mid-read and RD_LAT=2.
module tb_ram_master;

  logic       clk;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rsp_valid, rsp_last, busy;
  logic [7:0] rsp_data;
  logic       mem_w_en, mem_r_en;
  logic [3:0] mem_w_addr, mem_r_addr;
  logic [7:0] mem_w_data, mem_r_data;

  logic       cmd_valid2, cmd_ready2, cmd_write2;
  logic [3:0] cmd_addr2, cmd_len2;
  logic       wr_valid2, wr_ready2;
  logic [7:0] wr_data2;
  logic       rsp_valid2, rsp_last2, busy2;
  logic [7:0] rsp_data2;
  logic       mem_w_en2, mem_r_en2;
  logic [3:0] mem_w_addr2, mem_r_addr2;
  logic [7:0] mem_w_data2, mem_r_data2;

  int total = 0;
  int bad   = 0;

  ram_master #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
  );

  ram_master #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(cmd_write2),
    .cmd_addr(cmd_addr2), .cmd_len(cmd_len2),
    .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_data(wr_data2),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .rsp_last(rsp_last2), .busy(busy2),
    .mem_w_en(mem_w_en2), .mem_w_addr(mem_w_addr2), .mem_w_data(mem_w_data2),
    .mem_r_en(mem_r_en2), .mem_r_addr(mem_r_addr2), .mem_r_data(mem_r_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block RAM models: one-cycle and two-cycle read latency
  logic [7:0] ram1 [16];
  logic [7:0] ram2 [16];
  logic [7:0] ram2_s1;

  always @(posedge clk) begin
    if (mem_w_en) ram1[mem_w_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= ram1[mem_r_addr];
  end

  always @(posedge clk) begin
    if (mem_w_en2) ram2[mem_w_addr2] <= mem_w_data2;
    if (mem_r_en2) ram2_s1 <= ram2[mem_r_addr2];
    mem_r_data2 <= ram2_s1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       cv; logic cw; logic [3:0] ca; logic [3:0] cl; logic wv; logic [7:0] wd;
    logic       crdy; logic bsy; logic wrdy; logic wen; logic [3:0] wa; logic [7:0] wdt;
    logic       ren; logic [3:0] ra; logic rv; logic [7:0] rd; logic rl;
  } vec_t;

  localparam int NVEC = 22;
  vec_t tbl [NVEC];
  vec_t v;
  int   nrsp, nren, got;
  logic done;

  initial begin
    // cv cw ca cl wv wd | crdy bsy wrdy wen wa wdt ren ra rv rd rl
    tbl[0]  = '{1'b1,1'b1,4'hF,4'h0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,4'h0,8'h00,1'b0,4'h0,1'b0,8'h00,1'b0};
    tbl[1]  = '{1'b0,1'b0,4'h0,4'h0,1'b1,8'hA5, 1'b0,1'b1,1'b1,1'b1,4'hF,8'hA5,1'b0,4'h0,1'b0,8'h00,1'b0};
    tbl[2]  = '{1'b1,1'b0,4'hF,4'h0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,4'h0,8'h00,1'b0,4'h0,1'b0,8'h00,1'b0};
    tbl[3]  = '{1'b0,1'b0,4'h0,4'h0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,4'h0,8'h00,1'b1,4'hF,1'b0,8'h00,1'b0};
    tbl[4]  = '{1'b0,1'b0,4'h0,4'h0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,4'h0,8'h00,1'b0,4'h0,1'b0,8'h00,1'b0};
    tbl[5]  = '{1'b0,1'b0,4'h0,4'h0,1'b0,8'h00, 1'b1,1'b1,1'b0,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1,8'hA5,1'b1};
    tbl[6]  = '{1'b0,1'b0,4'h0,4'h0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,4'h0,8'h00,1'b0,4'h0,1'b0,8'h00,1'b0};
    tbl[7]  = '{1'b1,1'b1,4'hE,4'h3,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,4'h0,8'h00,1'b0,4'h0,1'b0,8'h00,1'b0};
    tbl[8]  = '{1'b0,1'b0,4'h0,4'h0,1'b1,8'h11, 1'b0,1'b1,1'b1,1'b1,4'hE,8'h11,1'b0,4'h0,1'b0,8'h00,1'b0};
    tbl[9]  = '{1'b0,1'b0,4'h0,4'h0,1'b1,8'h22, 1'b0,1'b1,1'b1,1'b1,4'hF,8'h22,1'b0,4'h0,1'b0,8'h00,1'b0};
    tbl[10] = '{1'b0,1'b0,4'h0,4'h0,1'b0,8'h99, 1'b0,1'b1,1'b1,1'b0,4'h0,8'h00,1'b0,4'h0,1'b0,8'h00,1'b0};
    tbl[11] = '{1'b0,1'b0,4'h0,4'h0,1'b0,8'h99, 1'b0,1'b1,1'b1,1'b0,4'h0,8'h00,1'b0,4'h0,1'b0,8'h00,1'b0};
    tbl[12] = '{1'b0,1'b0,4'h0,4'h0,1'b1,8'h33, 1'b0,1'b1,1'b1,1'b1,4'h0,8'h33,1'b0,4'h0,1'b0,8'h00,1'b0};
    tbl[13] = '{1'b0,1'b0,4'h0,4'h0,1'b1,8'h44, 1'b0,1'b1,1'b1,1'b1,4'h1,8'h44,1'b0,4'h0,1'b0,8'h00,1'b0};
    tbl[14] = '{1'b1,1'b0,4'hE,4'h3,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,4'h0,8'h00,1'b0,4'h0,1'b0,8'h00,1'b0};
    tbl[15] = '{1'b0,1'b0,4'h0,4'h0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,4'h0,8'h00,1'b1,4'hE,1'b0,8'h00,1'b0};
    tbl[16] = '{1'b0,1'b0,4'h0,4'h0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,4'h0,8'h00,1'b1,4'hF,1'b0,8'h00,1'b0};
    tbl[17] = '{1'b0,1'b0,4'h0,4'h0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,4'h0,8'h00,1'b1,4'h0,1'b1,8'h11,1'b0};
    tbl[18] = '{1'b0,1'b0,4'h0,4'h0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,4'h0,8'h00,1'b1,4'h1,1'b1,8'h22,1'b0};
    tbl[19] = '{1'b0,1'b0,4'h0,4'h0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1,8'h33,1'b0};
    tbl[20] = '{1'b0,1'b0,4'h0,4'h0,1'b0,8'h00, 1'b1,1'b1,1'b0,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1,8'h44,1'b1};
    tbl[21] = '{1'b0,1'b0,4'h0,4'h0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,4'h0,8'h00,1'b0,4'h0,1'b0,8'h00,1'b0};

    rst = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_len = 4'h0;
    wr_valid = 1'b0; wr_data = 8'h00;
    cmd_valid2 = 1'b0; cmd_write2 = 1'b0; cmd_addr2 = 4'h0; cmd_len2 = 4'h0;
    wr_valid2 = 1'b0; wr_data2 = 8'h00;

    // Reset values
    #2 rst = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_last", 32'(rsp_last), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_mem_w_en", 32'(mem_w_en), 32'd0);
    chk("rst_mem_r_en", 32'(mem_r_en), 32'd0);
    chk("rst_mem_w_addr", 32'(mem_w_addr), 32'd0);
    chk("rst_mem_w_data", 32'(mem_w_data), 32'd0);
    chk("rst_mem_r_addr", 32'(mem_r_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single write/read and wrapping write with gap, then read-back
    for (int i = 0; i < NVEC; i++) begin
      v = tbl[i];
      @(negedge clk);
      cmd_valid = v.cv; cmd_write = v.cw; cmd_addr = v.ca; cmd_len = v.cl;
      wr_valid = v.wv; wr_data = v.wd;
      #1;
      chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'(v.crdy));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(v.bsy));
      chk($sformatf("v%0d_wr_ready", i), 32'(wr_ready), 32'(v.wrdy));
      chk($sformatf("v%0d_mem_w_en", i), 32'(mem_w_en), 32'(v.wen));
      chk($sformatf("v%0d_mem_r_en", i), 32'(mem_r_en), 32'(v.ren));
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(v.rv));
      chk($sformatf("v%0d_rsp_last", i), 32'(rsp_last), 32'(v.rl));
      if (v.wen) begin
        chk($sformatf("v%0d_mem_w_addr", i), 32'(mem_w_addr), 32'(v.wa));
        chk($sformatf("v%0d_mem_w_data", i), 32'(mem_w_data), 32'(v.wdt));
      end
      if (v.ren) chk($sformatf("v%0d_mem_r_addr", i), 32'(mem_r_addr), 32'(v.ra));
      if (v.rv) chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(v.rd));
    end

    // Load mem[i] = i with a 16-beat write burst
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_len = 4'hF;
    #1 chk("fill_accept", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'(i);
      #1;
      chk("fill_w_en", 32'(mem_w_en), 32'd1);
      chk("fill_w_addr", 32'(mem_w_addr), 32'(i));
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1 chk("fill_busy_drop", 32'(busy), 32'd0);

    // Full read burst with a second read command held throughout
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_len = 4'hF;
    #1 chk("full_accept", 32'(cmd_ready), 32'd1);
    nrsp = 0; nren = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h3; cmd_len = 4'h1;
      #1;
      if (mem_r_en) begin
        chk("full_r_addr", 32'(mem_r_addr), 32'(nren));
        nren++;
      end
      if (nrsp > 0 || rsp_valid) begin
        chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("full_rsp_data", 32'(rsp_data), 32'(nrsp));
        chk("full_rsp_last", 32'(rsp_last), 32'(nrsp == 15));
        if (nrsp == 15) begin
          chk("full_last_cmd_ready", 32'(cmd_ready), 32'd1);
          done = 1'b1;
        end else begin
          chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        nrsp++;
      end else begin
        chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      end
    end
    chk("full_done", 32'(done), 32'd1);
    chk("full_r_count", 32'(nren), 32'd16);

    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("b2b_r_en", 32'(mem_r_en), 32'd1);
    chk("b2b_r_addr", 32'(mem_r_addr), 32'd3);
    got = 0;
    for (int c = 0; c < 10 && got < 2; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) begin
        chk("b2b_rsp_data", 32'(rsp_data), 32'(3 + got));
        chk("b2b_rsp_last", 32'(rsp_last), 32'(got == 1));
        got++;
      end
    end
    chk("b2b_count", 32'(got), 32'd2);
    @(negedge clk);
    #1;
    chk("b2b_no_extra", 32'(rsp_valid), 32'd0);
    chk("b2b_idle", 32'(busy), 32'd0);

    // Asynchronous reset during beat 5 of a 16-beat read
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_len = 4'hF;
    #1 chk("rr_accept", 32'(cmd_ready), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    #1;
    chk("rr_pre_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rr_pre_r_en", 32'(mem_r_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rr_r_en", 32'(mem_r_en), 32'd0);
    chk("rr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rr_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      chk("rr_post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rr_post_r_en", 32'(mem_r_en), 32'd0);
    end
    chk("rr_post_cmd_ready", 32'(cmd_ready), 32'd1);

    // RD_LAT=2: single write then read, response three cycles after mem_r_en
    @(negedge clk);
    cmd_valid2 = 1'b1; cmd_write2 = 1'b1; cmd_addr2 = 4'hF; cmd_len2 = 4'h0;
    #1 chk("l2_accept_w", 32'(cmd_ready2), 32'd1);
    @(negedge clk);
    cmd_valid2 = 1'b0; wr_valid2 = 1'b1; wr_data2 = 8'hA5;
    #1;
    chk("l2_w_en", 32'(mem_w_en2), 32'd1);
    chk("l2_w_addr", 32'(mem_w_addr2), 32'hF);
    chk("l2_w_data", 32'(mem_w_data2), 32'hA5);
    @(negedge clk);
    wr_valid2 = 1'b0; cmd_valid2 = 1'b1; cmd_write2 = 1'b0; cmd_addr2 = 4'hF;
    #1;
    chk("l2_w_done", 32'(mem_w_en2), 32'd0);
    chk("l2_accept_r", 32'(cmd_ready2), 32'd1);
    @(negedge clk);
    cmd_valid2 = 1'b0;
    #1;
    chk("l2_r_en", 32'(mem_r_en2), 32'd1);
    chk("l2_r_addr", 32'(mem_r_addr2), 32'hF);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      #1 chk("l2_rsp_early", 32'(rsp_valid2), 32'd0);
    end
    @(negedge clk);
    #1;
    chk("l2_rsp_valid", 32'(rsp_valid2), 32'd1);
    chk("l2_rsp_data", 32'(rsp_data2), 32'hA5);
    chk("l2_rsp_last", 32'(rsp_last2), 32'd1);
    chk("l2_cmd_ready", 32'(cmd_ready2), 32'd1);
    @(negedge clk);
    #1;
    chk("l2_rsp_after", 32'(rsp_valid2), 32'd0);
    chk("l2_idle", 32'(busy2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
